// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  localparam int DATA_BITS              = 8;
  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 10000;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // A frame's data bits plus its parity bit must carry an odd number of ones.
  function automatic logic oddWeight(input logic [DATA_BITS:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 pin conditioning: synchronizes both pins, debounces the PS/2 clock
// and emits a one-cycle strobe, with the sampled data bit, on each filtered
// falling edge of the PS/2 clock.
module ps2_edge_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2Clk,
  input  logic i_ps2Dat,
  output logic o_strobe,
  output logic o_bitData
);

  localparam int              CNT_W     = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       r_clkSync;
  logic [1:0]       r_datSync;
  logic [CNT_W-1:0] r_filtCnt;
  logic             r_clkFilt;
  logic             r_strobe;
  logic             r_bitData;

  // Two-stage synchronizers; they reset to 1 so the bus looks idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
    end else begin
      r_clkSync <= {r_clkSync[0], i_ps2Clk};
      r_datSync <= {r_datSync[0], i_ps2Dat};
    end
  end

  // Flip the filtered clock only after FILTER_LEN differing samples in a row;
  // a flip to low raises the strobe and latches the data pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filtCnt <= '0;
      r_clkFilt <= 1'b1;
      r_strobe  <= 1'b0;
      r_bitData <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
      if (r_clkSync[1] == r_clkFilt) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FILT_LAST) begin
        r_filtCnt <= '0;
        r_clkFilt <= r_clkSync[1];
        if (!r_clkSync[1]) begin
          r_strobe  <= 1'b1;
          r_bitData <= r_datSync[1];
        end
      end else begin
        r_filtCnt <= r_filtCnt + CNT_W'(1);
      end
    end
  end

  assign o_strobe  = r_strobe;
  assign o_bitData = r_bitData;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Good bytes are offered on a valid/ack handshake; bad frames
// and dropped good frames are reported with one-cycle pulses.
// Optional feature: define PS2_RX_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES clock cycles without a bit strobe.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] scancode,
  output logic       valid,
  input  logic       ack,
  output logic       frame_error,
  output logic       overrun
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            r_state;
  rx_state_t            w_stateNext;
  logic [2:0]           r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [7:0]           r_scancode;
  logic                 r_valid;
  logic                 r_frameError;
  logic                 r_overrun;
  logic                 w_strobe;
  logic                 w_bitData;
  logic                 w_frameDone;
  logic                 w_frameGood;
  logic                 w_timeout;
  logic                 w_take;

  // Both parameters size counters, so zero or negative values are rejected.
  if (FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
    $error("ps2_frame_receiver: FILTER_LEN and TIMEOUT_CYCLES must be positive");
  end

  ps2_edge_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_edgeFilter (
    .clk      (clk),
    .reset    (reset),
    .i_ps2Clk (ps2_clk_in),
    .i_ps2Dat (ps2_dat_in),
    .o_strobe (w_strobe),
    .o_bitData(w_bitData)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_toCnt;

  // Count silent cycles inside a frame; every bit strobe restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_toCnt <= '0;
    end else if (r_state == RX_IDLE || w_strobe) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state != RX_IDLE) && !w_strobe && (r_toCnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and frame verdict; the verdict is only meaningful on the stop strobe.
  always_comb begin
    w_stateNext = r_state;
    w_frameDone = 1'b0;
    w_frameGood = 1'b0;
    if (w_timeout) begin
      w_stateNext = RX_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        RX_IDLE:   if (!w_bitData) w_stateNext = RX_DATA;
        RX_DATA:   if (r_bitCnt == LAST_BIT) w_stateNext = RX_PARITY;
        RX_PARITY: w_stateNext = RX_STOP;
        RX_STOP: begin
          w_stateNext = RX_IDLE;
          w_frameDone = 1'b1;
          w_frameGood = w_bitData & oddWeight({r_shift, r_parity});
        end
        default:   w_stateNext = RX_IDLE;
      endcase
    end
  end

  // Shift register, bit counter and parity capture, advanced only on strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (w_strobe) begin
      case (r_state)
        RX_IDLE: r_bitCnt <= '0;
        RX_DATA: begin
          r_shift  <= {w_bitData, r_shift[DATA_BITS-1:1]};
          r_bitCnt <= r_bitCnt + 3'd1;
        end
        RX_PARITY: r_parity <= w_bitData;
        default: ;
      endcase
    end
  end

  assign w_take = r_valid & ack;

  // Output handshake: a good frame loads unless an unconsumed byte is still
  // held, in which case the new byte is dropped and overrun pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scancode   <= 8'h00;
      r_valid      <= 1'b0;
      r_frameError <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frameError <= (w_frameDone & ~w_frameGood) | w_timeout;
      r_overrun    <= 1'b0;
      if (w_frameDone && w_frameGood) begin
        if (r_valid && !ack) begin
          r_overrun <= 1'b1;
        end else begin
          r_scancode <= r_shift;
          r_valid    <= 1'b1;
        end
      end else if (w_take) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign scancode    = r_scancode;
  assign valid       = r_valid;
  assign frame_error = r_frameError;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: drives whole PS/2 frames and
// compares the handshake outputs against a transaction-level model.
module tb_ps2_frame_receiver;

  localparam int FILT = 8;
  localparam int TMO  = 600;
  localparam int HP   = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_dat_in = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] scancode;
  logic       valid;
  logic       frame_error;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;

  bit         expValid = 1'b0;
  logic [7:0] expCode = 8'h00;
  int         expErr = 0;
  int         expOvr = 0;
  int         obsErr = 0;
  int         obsOvr = 0;
  bit         settled = 1'b0;
  int         latency = 0;
  logic       ackAtEdge = 1'b0;
  bit         prevValid = 1'b0;
  logic [7:0] prevCode = 8'h00;
  bit         prevReset = 1'b1;

  always #5 clk = ~clk;

  ps2_frame_receiver #(
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .scancode   (scancode),
    .valid      (valid),
    .ack        (ack),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Frame bits in wire order: start, data LSB first, parity, stop.
  function automatic logic [10:0] mkFrame(input logic [7:0] b, input bit flipPar, input bit stopBit);
    logic p;
    p = ~(^b) ^ flipPar;
    return {stopBit, p, b, 1'b0};
  endfunction

  function automatic bit frameGood(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
  endfunction

  // Transaction-level model of one completed frame.
  task automatic modelFrame(input logic [10:0] f, input bit ackedAtStop);
    if (frameGood(f)) begin
      if (expValid && !ackedAtStop) expOvr++;
      else begin
        expValid = 1'b1;
        expCode  = f[8:1];
      end
    end else begin
      expErr++;
    end
  endtask

  // Drive bits first..last of a frame; ackAt > 0 raises ack for the posedge
  // that lies ackAt cycles after the stop bit's falling edge.
  task automatic applyStimulus(input logic [10:0] f, input int first, input int last, input int ackAt);
    for (int i = first; i <= last; i++) begin
      ps2_dat_in = f[i];
      repeat (HP) @(negedge clk);
      ps2_clk_in = 1'b0;
      for (int j = 1; j <= HP; j++) begin
        if (i == 10 && j == ackAt) ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (i == 10 && latency == 0 && valid) latency = j;
      end
      ps2_clk_in = 1'b1;
    end
    repeat (HP) @(negedge clk);
    ps2_dat_in = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit flipPar, input bit stopBit, input int ackAt);
    logic [10:0] f;
    f = mkFrame(b, flipPar, stopBit);
    settled = 1'b0;
    applyStimulus(f, 0, 10, ackAt);
    modelFrame(f, ackAt != 0);
    settled = 1'b1;
  endtask

  task automatic doAck();
    settled = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (expValid) expValid = 1'b0;
    @(negedge clk);
    settled = 1'b1;
  endtask

  task automatic checkOutput(input string name);
    compareValue({name, "_valid"}, 32'(valid), 32'(expValid));
    compareValue({name, "_scancode"}, 32'(scancode), 32'(expCode));
    compareValue({name, "_errors"}, 32'(obsErr), 32'(expErr));
    compareValue({name, "_overruns"}, 32'(obsOvr), 32'(expOvr));
  endtask

  always @(posedge clk) ackAtEdge <= ack;

  // Per-cycle checks: pulse exclusivity, byte hold while unacknowledged,
  // and agreement with the model whenever the bench is between transactions.
  always @(negedge clk) begin
    if (frame_error) obsErr++;
    if (overrun) obsOvr++;
    if (frame_error || overrun)
      compareValue("pulse_exclusive", 32'(frame_error & overrun), 32'd0);
    if (!reset && !prevReset && prevValid && !ackAtEdge) begin
      compareValue("hold_valid", 32'(valid), 32'd1);
      compareValue("hold_scancode", 32'(scancode), 32'(prevCode));
    end
    if (settled && !reset) begin
      compareValue("cycle_valid", 32'(valid), 32'(expValid));
      compareValue("cycle_scancode", 32'(scancode), 32'(expCode));
    end
    prevValid = valid;
    prevCode  = scancode;
    prevReset = reset;
  end

  initial begin
    logic [10:0] f;
    int errBase;
    int ovrBase;

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compareValue("reset_valid", 32'(valid), 32'd0);
    compareValue("reset_scancode", 32'(scancode), 32'h00);
    compareValue("reset_pulses", 32'({frame_error, overrun}), 32'd0);
    settled = 1'b1;
    checkOutput("reset");

    // Ack with nothing held is ignored.
    doAck();
    repeat (5) @(negedge clk);
    checkOutput("idle_ack");

    // Single good frame 0x1C; also measures stop-edge-to-valid latency.
    sendFrame(8'h1C, 1'b0, 1'b1, 0);
    checkOutput("frame_1c");
    compareValue("lit_1c", 32'(scancode), 32'h1C);
    compareValue("latency_measured", 32'(latency > 0 && latency < HP), 32'd1);
    doAck();
    checkOutput("ack_1c");

    // Two bytes in order, acked individually.
    sendFrame(8'hF0, 1'b0, 1'b1, 0);
    checkOutput("frame_f0");
    compareValue("lit_f0", 32'(scancode), 32'hF0);
    doAck();
    sendFrame(8'h1C, 1'b0, 1'b1, 0);
    checkOutput("frame_f0_1c");
    doAck();
    checkOutput("ack_f0_1c");

    // Bad parity and bad stop bit each give exactly one error pulse.
    errBase = obsErr;
    sendFrame(8'h1C, 1'b1, 1'b1, 0);
    checkOutput("bad_parity");
    compareValue("lit_parity_err", 32'(obsErr - errBase), 32'd1);
    sendFrame(8'h1C, 1'b0, 1'b0, 0);
    checkOutput("bad_stop");
    compareValue("lit_stop_err", 32'(obsErr - errBase), 32'd2);

    // Overrun: second good frame dropped while the first is unacknowledged.
    ovrBase = obsOvr;
    sendFrame(8'h1C, 1'b0, 1'b1, 0);
    sendFrame(8'h32, 1'b0, 1'b1, 0);
    checkOutput("overrun");
    compareValue("lit_overrun_code", 32'(scancode), 32'h1C);
    compareValue("lit_overrun_count", 32'(obsOvr - ovrBase), 32'd1);
    doAck();
    checkOutput("overrun_ack");

    // Ack in the same cycle a good frame completes: new byte, valid stays high.
    sendFrame(8'h1C, 1'b0, 1'b1, 0);
    sendFrame(8'h32, 1'b0, 1'b1, latency);
    checkOutput("same_cycle");
    compareValue("lit_same_cycle_code", 32'(scancode), 32'h32);
    doAck();

    // Short low glitch with data low must not be taken as a start bit.
    ps2_dat_in = 1'b0;
    ps2_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk_in = 1'b1;
    repeat (20) @(negedge clk);
    ps2_dat_in = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch");
    sendFrame(8'hF0, 1'b0, 1'b1, 0);
    checkOutput("after_glitch");
    compareValue("lit_after_glitch", 32'(scancode), 32'hF0);

    // Reset mid-frame drops partial data, clears the held byte, no pulse.
    settled = 1'b0;
    f = mkFrame(8'h5A, 1'b0, 1'b1);
    applyStimulus(f, 0, 4, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expValid = 1'b0;
    expCode  = 8'h00;
    repeat (100) @(negedge clk);
    settled = 1'b1;
    checkOutput("mid_reset");
    sendFrame(8'h1C, 1'b0, 1'b1, 0);
    checkOutput("after_reset");
    doAck();

    // Long silence in mid-frame.
    settled = 1'b0;
    f = mkFrame(8'h5A, 1'b0, 1'b1);
    applyStimulus(f, 0, 4, 0);
    repeat (TMO + 100) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    expErr++;
    settled = 1'b1;
    checkOutput("timeout");
    sendFrame(8'h5A, 1'b0, 1'b1, 0);
    checkOutput("after_timeout");
`else
    applyStimulus(f, 5, 10, 0);
    modelFrame(f, 1'b0);
    settled = 1'b1;
    checkOutput("no_timeout");
`endif
    compareValue("lit_5a", 32'(scancode), 32'h5A);
    doAck();
    checkOutput("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
